// File: rtl/aftab_daru_multi.sv
// Multi-byte aligned memory read unit: fetches 1/2/4/8 bytes one per memReady,
// assembles them little-endian and returns a sign- or zero-extended result.
module aftab_daru_multi #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              startDARU,
  input  logic [ADDR_W-1:0] addrIn,
  input  logic [1:0]        sizeIn,
  input  logic              signedLd,
  input  logic              abortDARU,
  input  logic              memReady,
  input  logic              memErr,
  input  logic [7:0]        dataBus,
  output logic [ADDR_W-1:0] addrBus,
  output logic              readMem,
  output logic [DATA_W-1:0] dataOut,
  output logic              busy,
  output logic              completeDARU,
  output logic              errDARU,
  output logic [1:0]        errCode
);

  localparam int LANES = DATA_W / 8;
  localparam int TW    = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, READ, DONE, ERR} stateT;

  stateT             state;
  logic [ADDR_W-1:0] addrLat;
  logic [1:0]        sizeLat;
  logic              signedLat;
  logic [2:0]        byteCnt;
  logic [TW-1:0]     tCnt;
  logic [DATA_W-1:0] asmReg;
  logic [DATA_W-1:0] asmNext;
  logic [2:0]        lastIdx;
  logic              aligned;
  logic              startOk;

  // Keep the low 8*2^sz bits and replicate bit (8*2^sz - 1) upward when signed.
  function automatic logic [DATA_W-1:0] extendLd(input logic [DATA_W-1:0] raw,
                                                 input logic [1:0] sz,
                                                 input logic sgn);
    logic signed [DATA_W-1:0] shl;
    int sh;
    sh = DATA_W - (8 << sz);
    if (sh < 0) sh = 0;
    shl = signed'(raw << sh);
    if (sgn) return shl >>> sh;
    else     return $unsigned(shl) >> sh;
  endfunction

  always_comb begin
    aligned = 1'b1;
    case (sizeIn)
      2'd1:    aligned = (addrIn[0] == 1'b0);
      2'd2:    aligned = (addrIn[1:0] == 2'b00);
      2'd3:    aligned = (addrIn[2:0] == 3'b000);
      default: aligned = 1'b1;
    endcase
    startOk = aligned && ((4'd1 << sizeIn) <= 4'(LANES));
  end

  always_comb begin
    asmNext = asmReg;
    for (int i = 0; i < LANES; i++)
      if (int'(byteCnt) == i) asmNext[8*i +: 8] = dataBus;
  end

  assign lastIdx = (3'd1 << sizeLat) - 3'd1;
  assign addrBus = addrLat + ADDR_W'(byteCnt);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      addrLat      <= '0;
      sizeLat      <= '0;
      signedLat    <= 1'b0;
      byteCnt      <= '0;
      tCnt         <= '0;
      asmReg       <= '0;
      dataOut      <= '0;
      errCode      <= '0;
      readMem      <= 1'b0;
      busy         <= 1'b0;
      completeDARU <= 1'b0;
      errDARU      <= 1'b0;
    end else begin
      completeDARU <= 1'b0;
      errDARU      <= 1'b0;
      case (state)
        IDLE: begin
          if (startDARU) begin
            addrLat   <= addrIn;
            sizeLat   <= sizeIn;
            signedLat <= signedLd;
            byteCnt   <= '0;
            tCnt      <= '0;
            asmReg    <= '0;
            busy      <= 1'b1;
            if (startOk) begin
              state   <= READ;
              readMem <= 1'b1;
              errCode <= 2'b00;
            end else begin
              state   <= ERR;
              errDARU <= 1'b1;
              errCode <= 2'b01;
            end
          end
        end
        READ: begin
          if (abortDARU) begin
            state   <= IDLE;
            readMem <= 1'b0;
            busy    <= 1'b0;
          end else if (memErr) begin
            state   <= ERR;
            readMem <= 1'b0;
            errDARU <= 1'b1;
            errCode <= 2'b10;
          end else if (memReady) begin
            asmReg  <= asmNext;
            byteCnt <= byteCnt + 3'd1;
            tCnt    <= '0;
            if (byteCnt == lastIdx) begin
              state        <= DONE;
              readMem      <= 1'b0;
              completeDARU <= 1'b1;
              dataOut      <= extendLd(asmNext, sizeLat, signedLat);
            end
          end else if (tCnt == TW'(TIMEOUT - 1)) begin
            state   <= ERR;
            readMem <= 1'b0;
            errDARU <= 1'b1;
            errCode <= 2'b11;
          end else begin
            tCnt <= tCnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_aftab_daru_multi.sv
// Randomized bench for aftab_daru_multi against a byte-list reference model.
module tb_aftab_daru_multi;

  localparam int DATA_W  = 32;
  localparam int ADDR_W  = 32;
  localparam int TIMEOUT = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic              startDARU;
  logic [ADDR_W-1:0] addrIn;
  logic [1:0]        sizeIn;
  logic              signedLd;
  logic              abortDARU;
  logic              memReady;
  logic              memErr;
  logic [7:0]        dataBus;
  logic [ADDR_W-1:0] addrBus;
  logic              readMem;
  logic [DATA_W-1:0] dataOut;
  logic              busy;
  logic              completeDARU;
  logic              errDARU;
  logic [1:0]        errCode;

  int nAssert = 0;
  int nFail   = 0;
  logic [31:0] modelData = '0;

  always #5 clk = ~clk;

  aftab_daru_multi #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .startDARU(startDARU), .addrIn(addrIn), .sizeIn(sizeIn),
    .signedLd(signedLd), .abortDARU(abortDARU), .memReady(memReady), .memErr(memErr),
    .dataBus(dataBus), .addrBus(addrBus), .readMem(readMem), .dataOut(dataOut),
    .busy(busy), .completeDARU(completeDARU), .errDARU(errDARU), .errCode(errCode)
  );

  task automatic checkEq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nAssert++;
    if (got !== exp) begin
      nFail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic issueStart(input logic [31:0] addr, input logic [1:0] sz, input bit sgn);
    @(negedge clk);
    startDARU = 1'b1; addrIn = addr; sizeIn = sz; signedLd = sgn;
    memReady = 1'b0; memErr = 1'b0; abortDARU = 1'b0;
  endtask

  // Full read with per-byte wait cycles; expectations from byte list arithmetic.
  task automatic doRead(input logic [31:0] addr, input logic [1:0] sz, input bit sgn,
                        input int maxDelay, input bit useFixed, input logic [63:0] fixedBytes,
                        input string tag);
    logic [7:0]  b[8];
    int          d[8];
    int          n, idx, cycles, expCycles, wait_;
    logic [63:0] v;
    logic [31:0] expData;
    bit          done;
    n = 1 << sz;
    v = '0;
    expCycles = n + 1;
    for (int i = 0; i < n; i++) begin
      b[i] = useFixed ? fixedBytes[8*i +: 8] : 8'($urandom);
      d[i] = $urandom_range(maxDelay, 0);
      expCycles += d[i];
      v = v | (64'(b[i]) << (8 * i));
    end
    if (sgn && b[n-1][7]) v = v | ({64{1'b1}} << (8 * n));
    expData = v[31:0];

    issueStart(addr, sz, sgn);
    idx = 0; cycles = 0; done = 1'b0; wait_ = d[0];
    while (!done && cycles < 200) begin
      @(negedge clk);
      cycles++;
      if (completeDARU) begin
        done = 1'b1;
        startDARU = 1'b0; memReady = 1'b0;
      end else begin
        checkEq({tag, " readMem"}, readMem, 1'b1);
        checkEq({tag, " addrBus"}, addrBus, addr + 32'(idx));
        checkEq({tag, " errDARU"}, errDARU, 1'b0);
        startDARU = 1'($urandom); addrIn = $urandom; sizeIn = 2'($urandom); signedLd = 1'($urandom);
        if (idx >= n) begin
          memReady = 1'b0;
        end else if (wait_ > 0) begin
          memReady = 1'b0; dataBus = 8'($urandom); wait_--;
        end else begin
          memReady = 1'b1; dataBus = b[idx]; idx++;
          if (idx < n) wait_ = d[idx];
        end
      end
    end
    checkEq({tag, " completed"}, done, 1'b1);
    checkEq({tag, " latency"}, cycles, expCycles);
    checkEq({tag, " dataOut"}, dataOut, expData);
    checkEq({tag, " busyDone"}, busy, 1'b1);
    checkEq({tag, " readMemDone"}, readMem, 1'b0);
    modelData = expData;
    @(negedge clk);
    checkEq({tag, " completeOnce"}, completeDARU, 1'b0);
    checkEq({tag, " busyIdle"}, busy, 1'b0);
    checkEq({tag, " dataHeld"}, dataOut, modelData);
  endtask

  task automatic errStart(input logic [31:0] addr, input logic [1:0] sz, input string tag);
    issueStart(addr, sz, 1'b0);
    @(negedge clk);
    startDARU = 1'b0;
    checkEq({tag, " errDARU"}, errDARU, 1'b1);
    checkEq({tag, " errCode"}, errCode, 2'b01);
    checkEq({tag, " readMem"}, readMem, 1'b0);
    checkEq({tag, " busy"}, busy, 1'b1);
    @(negedge clk);
    checkEq({tag, " errOnce"}, errDARU, 1'b0);
    checkEq({tag, " readMem2"}, readMem, 1'b0);
    checkEq({tag, " codeHeld"}, errCode, 2'b01);
    checkEq({tag, " dataHeld"}, dataOut, modelData);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    bit seen;
    logic [1:0] rsz;
    rst = 1'b0; startDARU = 1'b0; addrIn = '0; sizeIn = '0; signedLd = 1'b0;
    abortDARU = 1'b0; memReady = 1'b0; memErr = 1'b0; dataBus = '0;
    repeat (2) @(negedge clk);
    checkEq("rst addrBus", addrBus, 0);
    checkEq("rst readMem", readMem, 0);
    checkEq("rst dataOut", dataOut, 0);
    checkEq("rst busy", busy, 0);
    checkEq("rst complete", completeDARU, 0);
    checkEq("rst errDARU", errDARU, 0);
    checkEq("rst errCode", errCode, 0);
    rst = 1'b1;

    doRead(32'h100, 2'd2, 1'b0, 0, 1'b1, 64'h44332211, "word");
    doRead(32'h41, 2'd0, 1'b1, 0, 1'b1, 64'h80, "byteS");
    doRead(32'h41, 2'd0, 1'b0, 0, 1'b1, 64'h80, "byteU");
    doRead(32'h22, 2'd1, 1'b1, 2, 1'b1, 64'h8001, "halfS");
    doRead(32'hFFFF_FFFC, 2'd2, 1'b1, 1, 1'b1, 64'h8899AABB, "wordS");
    for (int t = 0; t < 20; t++) begin
      rsz = 2'($urandom_range(2, 0));
      doRead($urandom & ~((32'd1 << rsz) - 32'd1), rsz, 1'($urandom), $urandom_range(6, 0),
             1'b0, 64'h0, "rand");
    end

    errStart(32'h102, 2'd2, "misalign");
    errStart(32'h101, 2'd1, "misalignH");
    errStart(32'h108, 2'd3, "oversize");

    // Timeout with memReady held low
    issueStart(32'h200, 2'd2, 1'b0);
    k = 0; seen = 1'b0;
    while (!seen && k < 60) begin
      @(negedge clk);
      startDARU = 1'b0;
      k++;
      if (errDARU) seen = 1'b1;
    end
    checkEq("tmo seen", seen, 1'b1);
    checkEq("tmo cycles", k, TIMEOUT + 1);
    checkEq("tmo errCode", errCode, 2'b11);
    checkEq("tmo dataHeld", dataOut, modelData);
    @(negedge clk);
    checkEq("tmo errOnce", errDARU, 1'b0);
    checkEq("tmo busy", busy, 1'b0);

    // memErr beats memReady
    issueStart(32'h210, 2'd2, 1'b0);
    @(negedge clk);
    startDARU = 1'b0; memReady = 1'b1; memErr = 1'b1; dataBus = 8'hAB;
    @(negedge clk);
    memReady = 1'b0; memErr = 1'b0;
    checkEq("memErr errDARU", errDARU, 1'b1);
    checkEq("memErr errCode", errCode, 2'b10);
    checkEq("memErr complete", completeDARU, 1'b0);
    checkEq("memErr dataHeld", dataOut, modelData);
    @(negedge clk);
    checkEq("memErr busy", busy, 1'b0);

    // Abort after the 2nd byte, with memErr/memReady also high
    issueStart(32'h300, 2'd2, 1'b0);
    @(negedge clk); startDARU = 1'b0; memReady = 1'b1; dataBus = 8'h5A;
    @(negedge clk); dataBus = 8'hA5;
    @(negedge clk); abortDARU = 1'b1; memErr = 1'b1; dataBus = 8'h77;
    @(negedge clk); abortDARU = 1'b0; memErr = 1'b0; memReady = 1'b0;
    checkEq("abort busy", busy, 1'b0);
    checkEq("abort readMem", readMem, 1'b0);
    checkEq("abort dataHeld", dataOut, modelData);
    for (int i = 0; i < 3; i++) begin
      checkEq("abort noComplete", completeDARU, 1'b0);
      checkEq("abort noErr", errDARU, 1'b0);
      @(negedge clk);
    end

    // Asynchronous reset mid-READ
    issueStart(32'h400, 2'd2, 1'b0);
    @(negedge clk); startDARU = 1'b0; memReady = 1'b1; dataBus = 8'h12;
    @(negedge clk); memReady = 1'b0;
    #2 rst = 1'b0;
    #1;
    checkEq("arst readMem", readMem, 0);
    checkEq("arst busy", busy, 0);
    checkEq("arst addrBus", addrBus, 0);
    checkEq("arst dataOut", dataOut, 0);
    checkEq("arst errCode", errCode, 0);
    checkEq("arst complete", completeDARU, 0);
    checkEq("arst errDARU", errDARU, 0);
    modelData = '0;
    @(negedge clk);
    rst = 1'b1;
    doRead(32'h500, 2'd2, 1'b0, 0, 1'b1, 64'hDEADBEEF, "afterRst");

    $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
    $finish;
  end

endmodule
